// File: rtl/ps2_host_tx_if.sv
// CPU IO-port bus for the PS/2 host transmitter.
// The CPU side drives select/strobe/address/data and reads back dout.
interface ps2_host_tx_if;
    logic       sel;
    logic       wr;
    logic       addr;
    logic [7:0] din;
    logic [7:0] dout;

    modport master (output sel, output wr, output addr, output din, input dout);
    modport slave  (input sel, input wr, input addr, input din, output dout);
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard
// using request-to-send, device-clocked data bits, odd parity, stop and ack,
// driving the open-drain lines through pull-low enables. tx_busy lets the
// receive decoder ignore the clock edges of our own transfer.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 400,
    parameter int TIMEOUT_CYCLES = 60000
) (
    input  logic         clk,
    input  logic         reset_n,
    ps2_host_tx_if.slave bus,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe,
    output logic         tx_busy
);

    localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;          // inhibit timer, then watchdog
    logic [3:0]    bit_cnt, bit_n;      // falling edges seen this frame
    logic [7:0]    byte_q, byte_n;
    logic          parity_q, parity_n;
    logic          clk_oe_q, clk_oe_n;
    logic          data_oe_q, data_oe_n;
    logic          nack_q, nack_n;
    logic          timeout_q, timeout_n;
    logic          wd_run;

    logic [1:0]    clk_sync, data_sync;
    logic          clk_prev;
    logic          clk_s, data_s, fall;
    logic          wr_evt;

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];
    assign fall   = clk_prev & ~clk_s;
    assign wr_evt = bus.sel && bus.wr && (bus.addr == 1'b0);

    // Synchronise the asynchronous line levels; reset to the idle-high level
    // so leaving reset never looks like a falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
            clk_prev  <= clk_s;
        end
    end

    // State and datapath registers; reset releases both lines at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            byte_q    <= 8'h00;
            parity_q  <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            nack_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_cnt   <= bit_n;
            byte_q    <= byte_n;
            parity_q  <= parity_n;
            clk_oe_q  <= clk_oe_n;
            data_oe_q <= data_oe_n;
            nack_q    <= nack_n;
            timeout_q <= timeout_n;
        end
    end

    // Next-state logic: frame sequencing, flag updates and the watchdog.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_n     = bit_cnt;
        byte_n    = byte_q;
        parity_n  = parity_q;
        clk_oe_n  = clk_oe_q;
        data_oe_n = data_oe_q;
        nack_n    = nack_q;
        timeout_n = timeout_q;
        wd_run    = 1'b0;

        unique case (state)
            S_IDLE: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                if (wr_evt) begin
                    byte_n    = bus.din;
                    parity_n  = ~^bus.din;
                    nack_n    = 1'b0;
                    timeout_n = 1'b0;
                    cnt_n     = '0;
                    clk_oe_n  = 1'b1;
                    state_n   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                // Start bit goes low on the same edge the clock is released.
                if (cnt == INH_LAST) begin
                    clk_oe_n  = 1'b0;
                    data_oe_n = 1'b1;
                    cnt_n     = '0;
                    bit_n     = '0;
                    state_n   = S_SEND;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_SEND: begin
                if (fall) begin
                    cnt_n = '0;
                    bit_n = bit_cnt + 4'd1;
                    if (bit_cnt < 4'd8) begin
                        data_oe_n = ~byte_q[bit_cnt[2:0]];
                    end else if (bit_cnt == 4'd8) begin
                        data_oe_n = ~parity_q;
                    end else begin
                        data_oe_n = 1'b0;   // stop bit: line released
                        state_n   = S_ACK;
                    end
                end else begin
                    wd_run = 1'b1;
                end
            end
            S_ACK: begin
                if (fall) begin
                    cnt_n   = '0;
                    bit_n   = bit_cnt + 4'd1;
                    nack_n  = data_s;       // device pulls data low to ack
                    state_n = S_WAIT_IDLE;
                end else begin
                    wd_run = 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (fall) begin
                    cnt_n = '0;
                end else if (clk_s && data_s) begin
                    state_n = S_IDLE;
                end else begin
                    wd_run = 1'b1;
                end
            end
            default: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                state_n   = S_IDLE;
            end
        endcase

        // Watchdog only runs in cycles without a falling edge, so an edge
        // arriving on the expiry cycle wins.
        if (wd_run) begin
            if (cnt == TMO_LAST) begin
                timeout_n = 1'b1;
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                cnt_n     = '0;
                state_n   = S_IDLE;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_busy     = (state != S_IDLE);
    assign bus.dout    = bus.addr ? byte_q : {tx_busy, 5'b0, nack_q, timeout_q};

endmodule
